// File: rtl/ras_predictor.sv
// Return-address stack with a speculative copy driven by fetch-side kind
// predictions and a committed copy driven by resolved kinds; flush restores spec.
module ras_predictor #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pdc_valid,
  input  logic [ADDR_W-1:0] pc_pdc,
  input  logic [2:0]        kind_pdc,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              ret_hit,
  input  logic              cmt_valid,
  input  logic [ADDR_W-1:0] cmt_pc,
  input  logic [2:0]        cmt_kind,
  input  logic              flush,
  output logic [PTR_W:0]    spec_count
);

  localparam logic [2:0]   KIND_CALL = 3'd2;
  localparam logic [2:0]   KIND_RET  = 3'd3;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] spec_mem [DEPTH];
  logic [ADDR_W-1:0] cmt_mem  [DEPTH];
  logic [PTR_W-1:0]  spec_top, cmt_top;
  logic [PTR_W:0]    spec_cnt, cmt_cnt;

  logic              spec_push, spec_pop;
  logic [ADDR_W-1:0] spec_wdata;
  logic [PTR_W-1:0]  spec_top_nxt;
  logic [PTR_W:0]    spec_cnt_nxt;

  logic              cmt_push, cmt_pop;
  logic [ADDR_W-1:0] cmt_wdata;
  logic [PTR_W-1:0]  cmt_top_nxt;
  logic [PTR_W:0]    cmt_cnt_nxt;

  assign ret_addr   = spec_mem[spec_top - PTR_W'(1)];
  assign ret_hit    = pdc_valid && (kind_pdc == KIND_RET) && (spec_cnt != '0);
  assign spec_count = spec_cnt;

  // Predict side: next pointer/count if this cycle's query is applied.
  always_comb begin
    spec_push    = pdc_valid && (kind_pdc == KIND_CALL);
    spec_pop     = pdc_valid && (kind_pdc == KIND_RET) && (spec_cnt != '0);
    spec_wdata   = pc_pdc + ADDR_W'(4);
    spec_top_nxt = spec_top;
    spec_cnt_nxt = spec_cnt;
    if (spec_push) begin
      spec_top_nxt = spec_top + PTR_W'(1);
      if (spec_cnt != CNT_FULL) spec_cnt_nxt = spec_cnt + (PTR_W+1)'(1);
    end else if (spec_pop) begin
      spec_top_nxt = spec_top - PTR_W'(1);
      spec_cnt_nxt = spec_cnt - (PTR_W+1)'(1);
    end
  end

  // Commit side: same rules; the result also feeds the flush restore.
  always_comb begin
    cmt_push    = cmt_valid && (cmt_kind == KIND_CALL);
    cmt_pop     = cmt_valid && (cmt_kind == KIND_RET) && (cmt_cnt != '0);
    cmt_wdata   = cmt_pc + ADDR_W'(4);
    cmt_top_nxt = cmt_top;
    cmt_cnt_nxt = cmt_cnt;
    if (cmt_push) begin
      cmt_top_nxt = cmt_top + PTR_W'(1);
      if (cmt_cnt != CNT_FULL) cmt_cnt_nxt = cmt_cnt + (PTR_W+1)'(1);
    end else if (cmt_pop) begin
      cmt_top_nxt = cmt_top - PTR_W'(1);
      cmt_cnt_nxt = cmt_cnt - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_top <= '0;
      spec_cnt <= '0;
      cmt_top  <= '0;
      cmt_cnt  <= '0;
    end else begin
      cmt_top <= cmt_top_nxt;
      cmt_cnt <= cmt_cnt_nxt;
      if (flush) begin
        spec_top <= cmt_top_nxt;
        spec_cnt <= cmt_cnt_nxt;
      end else begin
        spec_top <= spec_top_nxt;
        spec_cnt <= spec_cnt_nxt;
      end
    end
  end

  // Contents are not reset; only pointers/counts define validity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (cmt_push) cmt_mem[cmt_top] <= cmt_wdata;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cmt_push && (cmt_top == PTR_W'(i))) spec_mem[i] <= cmt_wdata;
          else                                    spec_mem[i] <= cmt_mem[i];
        end
      end else if (spec_push) begin
        spec_mem[spec_top] <= spec_wdata;
      end
    end
  end

endmodule

// File: tb/tb_ras_predictor.sv
// Directed checks of the return-address stack: push/pop, underflow, wrap,
// flush restore (with same-cycle commit), and mid-operation reset.
module tb_ras_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pdc_valid;
  logic [31:0] pc_pdc;
  logic [2:0]  kind_pdc;
  logic [31:0] ret_addr;
  logic        ret_hit;
  logic        cmt_valid;
  logic [31:0] cmt_pc;
  logic [2:0]  cmt_kind;
  logic        flush;
  logic [3:0]  spec_count;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [2:0] K_NONE = 3'd0, K_DIR = 3'd1, K_CALL = 3'd2, K_RET = 3'd3, K_BAD = 3'd6;

  ras_predictor #(.DEPTH(8), .PTR_W(3), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .pdc_valid(pdc_valid), .pc_pdc(pc_pdc), .kind_pdc(kind_pdc),
    .ret_addr(ret_addr), .ret_hit(ret_hit),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_kind(cmt_kind),
    .flush(flush), .spec_count(spec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Inputs change just after the falling edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pdc(input logic v, input logic [31:0] pc, input logic [2:0] k);
    pdc_valid = v; pc_pdc = pc; kind_pdc = k;
  endtask

  task automatic cmt(input logic v, input logic [31:0] pc, input logic [2:0] k);
    cmt_valid = v; cmt_pc = pc; cmt_kind = k;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    pdc(1'b0, 32'h0, K_NONE);
    cmt(1'b0, 32'h0, K_NONE);
    tick();
    rst = 1'b0;
    #1;
    chk("reset_count", {28'h0, spec_count}, 32'd0);
    chk("reset_hit", {31'h0, ret_hit}, 32'd0);

    // Push/pop
    pdc(1'b1, 32'h1000, K_CALL); tick();
    pdc(1'b1, 32'h2000, K_CALL); tick();
    pdc(1'b1, 32'h0040, K_RET); #1;
    chk("pp_count2", {28'h0, spec_count}, 32'd2);
    chk("pp_addr1", ret_addr, 32'h2004);
    chk("pp_hit1", {31'h0, ret_hit}, 32'd1);
    tick(); #1;
    chk("pp_count1", {28'h0, spec_count}, 32'd1);
    chk("pp_addr2", ret_addr, 32'h1004);
    chk("pp_hit2", {31'h0, ret_hit}, 32'd1);
    tick(); #1;
    chk("pp_count0", {28'h0, spec_count}, 32'd0);

    // Underflow and no-op kinds
    chk("uf_hit", {31'h0, ret_hit}, 32'd0);
    tick(); #1;
    chk("uf_count", {28'h0, spec_count}, 32'd0);
    pdc(1'b1, 32'h3000, K_CALL); tick();
    pdc(1'b1, 32'h3100, K_BAD);  tick();
    pdc(1'b1, 32'h3200, K_DIR);  tick();
    pdc(1'b1, 32'h3300, K_RET); #1;
    chk("noop_count", {28'h0, spec_count}, 32'd1);
    chk("uf_addr", ret_addr, 32'h3004);
    chk("uf_hit2", {31'h0, ret_hit}, 32'd1);
    tick(); #1;
    chk("uf_count_after", {28'h0, spec_count}, 32'd0);

    // Overflow wrap: 10 calls into 8 entries
    for (int i = 1; i <= 10; i++) begin
      pdc(1'b1, 32'(i) * 32'h100, K_CALL);
      tick();
    end
    pdc(1'b1, 32'h0, K_RET); #1;
    chk("ov_count", {28'h0, spec_count}, 32'd8);
    for (int i = 10; i >= 3; i--) begin
      chk($sformatf("ov_addr_%0d", i), ret_addr, 32'(i) * 32'h100 + 32'h4);
      chk($sformatf("ov_hit_%0d", i), {31'h0, ret_hit}, 32'd1);
      tick(); #1;
    end
    chk("ov_hit_9th", {31'h0, ret_hit}, 32'd0);
    chk("ov_count_end", {28'h0, spec_count}, 32'd0);

    // Flush restore
    pdc(1'b1, 32'h5000, K_CALL); cmt(1'b1, 32'h5000, K_CALL); tick();
    cmt(1'b0, 32'h0, K_NONE);
    pdc(1'b1, 32'h6000, K_CALL); tick();
    pdc(1'b1, 32'h7000, K_CALL); tick();
    pdc(1'b0, 32'h0, K_NONE); #1;
    chk("fl_pre_count", {28'h0, spec_count}, 32'd3);
    flush = 1'b1; tick(); flush = 1'b0;
    pdc(1'b1, 32'h0, K_RET); #1;
    chk("fl_count", {28'h0, spec_count}, 32'd1);
    chk("fl_addr", ret_addr, 32'h5004);
    chk("fl_hit", {31'h0, ret_hit}, 32'd1);

    // Flush with same-cycle commit and predict
    pdc(1'b1, 32'h9000, K_CALL); cmt(1'b1, 32'h8000, K_CALL); flush = 1'b1;
    tick();
    flush = 1'b0; cmt(1'b0, 32'h0, K_NONE);
    pdc(1'b1, 32'h0, K_RET); #1;
    chk("fc_count", {28'h0, spec_count}, 32'd2);
    chk("fc_addr", ret_addr, 32'h8004);
    tick(); #1;
    chk("fc_addr_below", ret_addr, 32'h5004);
    chk("fc_count_after", {28'h0, spec_count}, 32'd1);

    // Reset mid-operation
    pdc(1'b1, 32'hA000, K_CALL); tick();
    pdc(1'b1, 32'hB000, K_CALL); tick();
    pdc(1'b1, 32'hC000, K_CALL); tick(); #1;
    chk("rm_pre_count", {28'h0, spec_count}, 32'd4);
    rst = 1'b1;
    pdc(1'b1, 32'hD000, K_CALL); cmt(1'b1, 32'hE000, K_CALL);
    tick();
    rst = 1'b0;
    pdc(1'b0, 32'h0, K_NONE); cmt(1'b0, 32'h0, K_NONE); #1;
    chk("rm_count", {28'h0, spec_count}, 32'd0);
    chk("rm_hit", {31'h0, ret_hit}, 32'd0);
    pdc(1'b1, 32'h0, K_RET); #1;
    chk("rm_ret_hit", {31'h0, ret_hit}, 32'd0);
    pdc(1'b0, 32'h0, K_NONE);
    flush = 1'b1; tick(); flush = 1'b0; #1;
    chk("rm_cmt_cleared", {28'h0, spec_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
